// File: rtl/barrel_pkg.sv
// Shared types and constants for the barrel mover: slot FSM state and position width.
package barrel_pkg;

  localparam int POS_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROLL = 2'd1,
    ST_DROP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/barrel_mover_if.sv
// Launch-controller <-> barrel mover bus: per-slot launch/done handshake and packed positions.
interface barrel_mover_if #(
  parameter int BARRELS = 5
);
  import barrel_pkg::*;

  logic                     start_game;
  logic [BARRELS-1:0]       barrel;
  logic [BARRELS-1:0]       done;
  logic [BARRELS-1:0]       active;
  logic [BARRELS*POS_W-1:0] xpos;
  logic [BARRELS*POS_W-1:0] ypos;

  modport master (output start_game, output barrel,
                  input done, input active, input xpos, input ypos);
  modport slave  (input start_game, input barrel,
                  output done, output active, output xpos, output ypos);
endinterface

// File: rtl/barrel_slot.sv
// One barrel slot: launch/abort handshake, roll/drop FSM and registered position outputs.
// Optional BARREL_SPEEDUP_EN: step grows by one pixel per completed platform.
module barrel_slot
  import barrel_pkg::*;
#(
  parameter int X_MIN   = 64,
  parameter int X_MAX   = 960,
  parameter int X_START = 64,
  parameter int Y_START = 128,
  parameter int STEP    = 2,
  parameter int LEVEL_H = 96,
  parameter int LEVELS  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move_tick,
  input  logic             start_game,
  input  logic             barrel,
  output logic             done,
  output logic             active,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos
);

  state_t             state_r, state_s;
  logic [POS_W-1:0]   x_r, x_s, y_r, y_s;
  logic [POS_W-1:0]   level_r, level_s, drop_cnt_r, drop_cnt_s;
  logic               dir_left_r, dir_left_s;
  logic               barrel_prev_r, done_r, active_r;
  logic [POS_W-1:0]   step_s;
  logic [POS_W:0]     x_up_s, drop_sum_s;
  logic               launch_s, hit_right_s, hit_left_s, level_end_s, last_level_s;

`ifdef BARREL_SPEEDUP_EN
  assign step_s = POS_W'(STEP) + level_r;
`else
  assign step_s = POS_W'(STEP);
`endif

  // Comparisons are done one bit wider so a step can never wrap past the bounds.
  assign launch_s     = barrel & ~barrel_prev_r;
  assign x_up_s       = {1'b0, x_r} + {1'b0, step_s};
  assign hit_right_s  = x_up_s >= (POS_W+1)'(X_MAX);
  assign hit_left_s   = {1'b0, x_r} <= ((POS_W+1)'(X_MIN) + {1'b0, step_s});
  assign drop_sum_s   = {1'b0, drop_cnt_r} + {1'b0, step_s};
  assign level_end_s  = drop_sum_s >= (POS_W+1)'(LEVEL_H);
  assign last_level_s = (level_r + POS_W'(1)) == POS_W'(LEVELS);

  // Next-state and next-position logic for the slot FSM.
  always_comb begin
    state_s    = state_r;
    x_s        = x_r;
    y_s        = y_r;
    level_s    = level_r;
    drop_cnt_s = drop_cnt_r;
    dir_left_s = dir_left_r;
    if (!start_game) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            state_s    = ST_ROLL;
            x_s        = POS_W'(X_START);
            y_s        = POS_W'(Y_START);
            level_s    = {POS_W{1'b0}};
            drop_cnt_s = {POS_W{1'b0}};
            dir_left_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ROLL: begin
          if (!barrel) begin
            state_s = ST_IDLE;
          end else if (move_tick) begin
            if (!dir_left_r) begin
              if (hit_right_s) begin
                x_s     = POS_W'(X_MAX);
                state_s = ST_DROP;
              end else begin
                x_s     = x_up_s[POS_W-1:0];
                state_s = ST_ROLL;
              end
            end else begin
              if (hit_left_s) begin
                x_s     = POS_W'(X_MIN);
                state_s = ST_DROP;
              end else begin
                x_s     = x_r - step_s;
                state_s = ST_ROLL;
              end
            end
          end else begin
            state_s = ST_ROLL;
          end
        end
        ST_DROP: begin
          if (!barrel) begin
            state_s = ST_IDLE;
          end else if (move_tick) begin
            y_s = y_r + step_s;
            if (level_end_s) begin
              level_s    = level_r + POS_W'(1);
              drop_cnt_s = {POS_W{1'b0}};
              dir_left_s = ~dir_left_r;
              state_s    = last_level_s ? ST_DONE : ST_ROLL;
            end else begin
              drop_cnt_s = drop_sum_s[POS_W-1:0];
              state_s    = ST_DROP;
            end
          end else begin
            state_s = ST_DROP;
          end
        end
        ST_DONE: begin
          if (!barrel) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, position and flag registers; done/active follow the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      x_r           <= POS_W'(X_START);
      y_r           <= POS_W'(Y_START);
      level_r       <= {POS_W{1'b0}};
      drop_cnt_r    <= {POS_W{1'b0}};
      dir_left_r    <= 1'b0;
      barrel_prev_r <= 1'b0;
      done_r        <= 1'b0;
      active_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      x_r           <= x_s;
      y_r           <= y_s;
      level_r       <= level_s;
      drop_cnt_r    <= drop_cnt_s;
      dir_left_r    <= dir_left_s;
      barrel_prev_r <= barrel;
      done_r        <= (state_s == ST_DONE);
      active_r      <= (state_s == ST_ROLL) || (state_s == ST_DROP);
    end
  end

  assign done   = done_r;
  assign active = active_r;
  assign xpos   = x_r;
  assign ypos   = y_r;

endmodule

// File: rtl/barrel_mover.sv
// Barrel mover top: shared move-tick divider feeding BARRELS independent barrel_slot instances.
// Optional feature macro: BARREL_SPEEDUP_EN (per-platform speed-up, implemented in barrel_slot).
module barrel_mover
  import barrel_pkg::*;
#(
  parameter int BARRELS  = 5,
  parameter int TICK_DIV = 1_625_000,
  parameter int X_MIN    = 64,
  parameter int X_MAX    = 960,
  parameter int X_START  = 64,
  parameter int Y_START  = 128,
  parameter int STEP     = 2,
  parameter int LEVEL_H  = 96,
  parameter int LEVELS   = 5
) (
  input  logic           clk,
  input  logic           rst,
  barrel_mover_if.slave  bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_r;
  logic             move_tick_s;

  assign move_tick_s = (div_cnt_r == DIV_W'(TICK_DIV - 1));

  // Free-running move-tick divider shared by every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (move_tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  for (genvar i = 0; i < BARRELS; i++) begin : g_slot
    barrel_slot #(
      .X_MIN   (X_MIN),
      .X_MAX   (X_MAX),
      .X_START (X_START),
      .Y_START (Y_START),
      .STEP    (STEP),
      .LEVEL_H (LEVEL_H),
      .LEVELS  (LEVELS)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .move_tick  (move_tick_s),
      .start_game (bus.start_game),
      .barrel     (bus.barrel[i]),
      .done       (bus.done[i]),
      .active     (bus.active[i]),
      .xpos       (bus.xpos[i*POS_W +: POS_W]),
      .ypos       (bus.ypos[i*POS_W +: POS_W])
    );
  end

endmodule

// File: tb/tb_barrel_mover.sv
// Self-checking bench for barrel_mover: trajectory table, directed corner cases, and
// randomized launches/aborts compared against a trajectory-index reference model.
module tb_barrel_mover;
  import barrel_pkg::*;

  localparam int NB = 5, TDIV = 4, XMIN = 16, XMAX = 32, XST = 16, YST = 0;
  localparam int STP = 4, LH = 8, NLV = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  barrel_mover_if #(.BARRELS(NB)) bi ();

  barrel_mover #(
    .BARRELS(NB), .TICK_DIV(TDIV), .X_MIN(XMIN), .X_MAX(XMAX), .X_START(XST),
    .Y_START(YST), .STEP(STP), .LEVEL_H(LH), .LEVELS(NLV)
  ) dut (.clk(clk), .rst(rst), .bus(bi.slave));

  typedef enum int {M_IDLE, M_FLY, M_DONE} mstate_t;
  typedef struct {
    logic hold;
    int   x;
    int   y;
    logic act;
    logic dn;
  } vec_t;

  mstate_t mst[NB];
  int      mk[NB], mx[NB], my[NB];
  logic    mprev[NB];
  int      div_cnt = 0;
  logic    edge_tick = 1'b0;
  int      traj_x[$], traj_y[$];
  int      n_pass = 0, n_total = 0;
  vec_t    tbl[12];
  int      tx[12], ty[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Whole flight path from the movement rules, one entry per tick (entry 0 = spawn point).
  task automatic build_traj();
    int x = XST, y = YST, dir = 1, lvl = 0, d = 0, stp;
    bit rolling = 1'b1;
    traj_x.push_back(x); traj_y.push_back(y);
    while (lvl < NLV) begin
      stp = STP;
`ifdef BARREL_SPEEDUP_EN
      stp = STP + lvl;
`endif
      if (rolling) begin
        x = x + dir * stp;
        if (dir > 0 && x >= XMAX) begin x = XMAX; rolling = 1'b0; end
        else if (dir < 0 && x <= XMIN) begin x = XMIN; rolling = 1'b0; end
      end else begin
        y = y + stp; d = d + stp;
        if (d >= LH) begin lvl++; d = 0; dir = -dir; rolling = 1'b1; end
      end
      traj_x.push_back(x); traj_y.push_back(y);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      div_cnt = 0; edge_tick = 1'b0;
      for (int i = 0; i < NB; i++) begin
        mst[i] = M_IDLE; mx[i] = XST; my[i] = YST; mprev[i] = 1'b0; mk[i] = 0;
      end
    end else begin
      edge_tick = (div_cnt == TDIV - 1);
      div_cnt = edge_tick ? 0 : div_cnt + 1;
      for (int i = 0; i < NB; i++) begin
        case (mst[i])
          M_IDLE: if (bi.start_game && bi.barrel[i] && !mprev[i]) begin
            mst[i] = M_FLY; mk[i] = 0; mx[i] = traj_x[0]; my[i] = traj_y[0];
          end
          M_FLY: if (!bi.start_game || !bi.barrel[i]) mst[i] = M_IDLE;
            else if (edge_tick) begin
              mk[i]++; mx[i] = traj_x[mk[i]]; my[i] = traj_y[mk[i]];
              if (mk[i] == traj_x.size() - 1) mst[i] = M_DONE;
            end
          default: if (!bi.start_game || !bi.barrel[i]) mst[i] = M_IDLE;
        endcase
        mprev[i] = bi.barrel[i];
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [NB-1:0] ed, ea;
    logic [NB*POS_W-1:0] ex, ey;
    for (int i = 0; i < NB; i++) begin
      ed[i] = (mst[i] == M_DONE);
      ea[i] = (mst[i] == M_FLY);
      ex[i*POS_W +: POS_W] = POS_W'(mx[i]);
      ey[i*POS_W +: POS_W] = POS_W'(my[i]);
    end
    chk({tag, "_done"}, 64'(bi.done), 64'(ed));
    chk({tag, "_active"}, 64'(bi.active), 64'(ea));
    chk({tag, "_xpos"}, 64'(bi.xpos), 64'(ex));
    chk({tag, "_ypos"}, 64'(bi.ypos), 64'(ey));
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin cyc(); n++; end while (!edge_tick && n < TDIV + 1);
    if (!edge_tick) chk("tick_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    logic seen;
    build_traj();
`ifdef BARREL_SPEEDUP_EN
    tx = '{20, 24, 28, 32, 32, 32, 27, 22, 17, 16, 16, 16};
    ty = '{0, 0, 0, 0, 4, 8, 8, 8, 8, 8, 13, 18};
`else
    tx = '{20, 24, 28, 32, 32, 32, 28, 24, 20, 16, 16, 16};
    ty = '{0, 0, 0, 0, 4, 8, 8, 8, 8, 8, 12, 16};
`endif
    for (int j = 0; j < 12; j++) tbl[j] = '{hold: 1'b1, x: tx[j], y: ty[j], act: (j < 11), dn: (j == 11)};

    rst = 1'b1; bi.start_game = 1'b0; bi.barrel = '0;
    repeat (3) cyc();
    chk("rst_xpos0", 64'(bi.xpos[POS_W-1:0]), 64'(XST));
    chk("rst_ypos0", 64'(bi.ypos[POS_W-1:0]), 64'(YST));
    check_all("reset");
    rst = 1'b0; bi.start_game = 1'b1;
    cyc(); cyc();

    // Full flight of slot 0 against the hand-written table.
    bi.barrel[0] = 1'b1; cyc();
    chk("launch_active0", 64'(bi.active[0]), 64'd1);
    for (int j = 0; j < 12; j++) begin
      bi.barrel[0] = tbl[j].hold;
      wait_tick();
      chk("tbl_x", 64'(bi.xpos[POS_W-1:0]), 64'(tbl[j].x));
      chk("tbl_y", 64'(bi.ypos[POS_W-1:0]), 64'(tbl[j].y));
      chk("tbl_active", 64'(bi.active[0]), 64'(tbl[j].act));
      chk("tbl_done", 64'(bi.done[0]), 64'(tbl[j].dn));
    end

    // Release from DONE, then relaunch.
    bi.barrel[0] = 1'b0; cyc();
    chk("release_done0", 64'(bi.done[0]), 64'd0);
    check_all("release");
    bi.barrel[0] = 1'b1; cyc();
    chk("relaunch_active0", 64'(bi.active[0]), 64'd1);
    bi.barrel[0] = 1'b0; cyc();

    // Abort slot 1 mid-roll.
    bi.barrel[1] = 1'b1; cyc();
    repeat (3) wait_tick();
    bi.barrel[1] = 1'b0; cyc();
    chk("abort_active1", 64'(bi.active[1]), 64'd0);
    chk("abort_hold_x1", 64'(bi.xpos[POS_W +: POS_W]), 64'd28);
    seen = 1'b0;
    repeat (20) begin cyc(); if (bi.done[1]) seen = 1'b1; end
    chk("abort_no_done1", 64'(seen), 64'd0);

    // Simultaneous launch of slots 0 and 4.
    bi.barrel[0] = 1'b1; bi.barrel[4] = 1'b1; cyc();
    n = 0;
    while (mst[0] != M_DONE && n < 200) begin cyc(); check_all("pair"); n++; end
    chk("pair_timeout", 64'(n < 200), 64'd1);
    chk("pair_done0", 64'(bi.done[0]), 64'd1);
    chk("pair_done4", 64'(bi.done[4]), 64'd1);
    bi.barrel = '0; cyc();

    // start_game low mid-roll.
    bi.barrel[2] = 1'b1; cyc();
    repeat (2) wait_tick();
    bi.start_game = 1'b0; cyc();
    chk("stop_active", 64'(bi.active), 64'd0);
    chk("stop_done", 64'(bi.done), 64'd0);
    bi.start_game = 1'b1; bi.barrel[2] = 1'b0; cyc();

    // Reset mid-drop.
    bi.barrel[2] = 1'b1; cyc();
    repeat (5) wait_tick();
    rst = 1'b1; cyc();
    chk("rst_x2", 64'(bi.xpos[2*POS_W +: POS_W]), 64'(XST));
    chk("rst_y2", 64'(bi.ypos[2*POS_W +: POS_W]), 64'(YST));
    chk("rst_active", 64'(bi.active), 64'd0);
    bi.barrel = '0; rst = 1'b0; cyc();
    check_all("post_rst");

    // Randomized launches, aborts, game stops and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(79, 0) == 0) bi.barrel[i] = ~bi.barrel[i];
      if (bi.start_game) begin
        if ($urandom_range(399, 0) == 0) bi.start_game = 1'b0;
      end else begin
        if ($urandom_range(4, 0) == 0) bi.start_game = 1'b1;
      end
      rst = ($urandom_range(999, 0) == 0);
      cyc();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
